fifo_frame_reader: RTL and testbench

//  Read side of the 32-bit sample FIFO: pops words using the FIFO RD/EMPTY/dataOut interface
//  and delivers them to the FFT input stage over a VALID/READY stream.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fifo_frame_reader_if.sv | 44 ++++
 rtl/fifo_rd_skid.sv | 49 ++++
 rtl/fifo_frame_reader.sv | 102 ++++++++++
 tb/tb_fifo_frame_reader.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT sample input path.
package fft_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fifo_frame_reader_if.sv
// FIFO read port plus FFT-side sample stream of the frame reader.
interface fifo_frame_reader_if #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int IDX_W  = fft_pkg::IDX_W
);

    logic              en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;
    logic              last;
    logic [IDX_W-1:0]  sample_idx;
    logic              busy;

    modport master (
        input  en,
        input  fifo_empty,
        input  fifo_data,
        input  ready,
        output fifo_rd,
        output data_out,
        output valid,
        output last,
        output sample_idx,
        output busy
    );

    modport slave (
        output en,
        output fifo_empty,
        output fifo_data,
        output ready,
        input  fifo_rd,
        input  data_out,
        input  valid,
        input  last,
        input  sample_idx,
        input  busy
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry buffer that lands FIFO read data one cycle after the strobe
// and always presents the oldest word at head.
module fifo_rd_skid #(
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
        end else if (rd_en) begin
            rd_ptr <= ~rd_ptr;
        end
    end

    // The reader never writes into a full buffer unless the head leaves in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_frame_reader.sv
// Read side of the sample FIFO: issues FIFO reads, lands data in a 2-entry skid buffer
// and streams it to the FFT input tagged with its position in the frame.
module fifo_frame_reader #(
    parameter int DATA_W    = fft_pkg::DATA_W,
    parameter int FRAME_LEN = fft_pkg::FRAME_LEN,
    parameter int IDX_W     = fft_pkg::IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    fifo_frame_reader_if.master bus
);
    import fft_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic              inflight;
    logic [1:0]        count;
    logic [DATA_W-1:0] head;
    logic [IDX_W-1:0]  idx;
    logic              xfer;
    logic              pending;
    logic [2:0]        occupancy;

    assign xfer    = bus.valid & bus.ready;
    assign pending = (count != 2'd0) | inflight;

    // Buffered plus in-flight words, less the one leaving now; a new read must still fit.
    assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, xfer};
    assign bus.fifo_rd = bus.en & ~bus.fifo_empty & (occupancy < 3'd2) & ~rst;

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data (bus.fifo_data),
        .rd_en   (xfer),
        .head    (head),
        .count   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_rd;
        end
    end

    // Frame position only moves on an accepted sample; EN never touches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (!bus.en) begin
                    state_nxt = pending ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (bus.en) begin
                    state_nxt = STREAM;
                end else if (!pending) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.valid      = (count != 2'd0);
    assign bus.data_out   = head;
    assign bus.sample_idx = idx;
    assign bus.last       = bus.valid & (idx == LAST_IDX);
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench: a behavioural sample FIFO feeds the reader, and a queue model of
// the written words predicts every delivered sample, its frame index and LAST flag.
module tb_fifo_frame_reader;
    import fft_pkg::*;

    localparam int FL = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_frame_reader_if #(.DATA_W(DATA_W), .IDX_W(IW)) bus ();

    fifo_frame_reader #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FL),
        .IDX_W     (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Sample FIFO with a one-cycle read latency.
    logic       fifo_wr;
    logic       fifo_clr;
    sample_t    fifo_wdata;
    sample_t    fmem [64];
    logic [6:0] fw;
    logic [6:0] fr;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fw <= '0;
            fr <= '0;
        end else begin
            if (fifo_wr) begin
                fmem[fw[5:0]] <= fifo_wdata;
                fw            <= fw + 7'd1;
            end
            if (bus.fifo_rd) begin
                bus.fifo_data <= fmem[fr[5:0]];
                fr            <= fr + 7'd1;
            end
        end
    end

    assign bus.fifo_empty = (fw == fr);

    int      checks = 0;
    int      errors = 0;
    sample_t expq[$];
    int      exp_idx;
    int      occ;
    int      delivered;
    logic    hold_prev;
    sample_t data_prev;

    function automatic sample_t exp_head();
        if (expq.size() == 0) return 'x;
        return expq[0];
    endfunction

    task automatic drive(input logic e, input logic r, input logic w, input sample_t d);
        bus.en     = e;
        bus.ready  = r;
        fifo_wr    = w;
        fifo_wdata = d;
        if (w) expq.push_back(d);
        #1;
    endtask

    // Model bookkeeping for the cycle just observed, then move to the next cycle.
    task automatic advance();
        logic rd_s;
        logic x_s;
        rd_s      = bus.fifo_rd;
        x_s       = bus.valid & bus.ready;
        hold_prev = bus.valid & ~bus.ready;
        data_prev = bus.data_out;
        if (rd_s) occ++;
        if (x_s) begin
            occ--;
            delivered++;
            if (expq.size() != 0) void'(expq.pop_front());
            exp_idx = (exp_idx + 1) % FL;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        fifo_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        fifo_clr  = 1'b0;
        rst       = 1'b0;
        expq.delete();
        exp_idx   = 0;
        occ       = 0;
        delivered = 0;
        hold_prev = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst      = 1'b1;
        fifo_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #2;
        fifo_clr = 1'b0;
        drive(1'b1, 1'b1, 1'b1, $urandom);
        @(posedge clk);
        #2;
        drive(1'b1, 1'b1, 1'b0, '0);
        checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_rd: got %b want 0", bus.fifo_rd); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b want 0", bus.last); end
        checks++; if (bus.data_out !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", bus.data_out); end
        checks++; if (bus.sample_idx !== '0) begin errors++; $display("[TB] FAIL reset_idx: got %0d want 0", bus.sample_idx); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        do_reset();
    endtask

    task automatic test_stream();
        int first_rd, first_v, first_x, last_x;
        $display("[TB] test_stream");
        first_rd = -1; first_v = -1; first_x = -1; last_x = -1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, sample_t'(i));
            advance();
        end
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (bus.fifo_rd && first_rd < 0) first_rd = c;
            if (bus.valid) begin
                if (first_v < 0) first_v = c;
                if (first_x < 0) first_x = c;
                last_x = c;
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL stream_data: got %h want %h", bus.data_out, exp_head()); end
                checks++; if (bus.sample_idx !== IW'(exp_idx)) begin errors++; $display("[TB] FAIL stream_idx: got %0d want %0d", bus.sample_idx, exp_idx); end
                checks++; if (bus.last !== (exp_idx == FL - 1)) begin errors++; $display("[TB] FAIL stream_last: got %b want %b", bus.last, exp_idx == FL - 1); end
            end else begin
                checks++; if (bus.last !== 1'b0) begin errors++; $display("[TB] FAIL stream_last_idle: got %b want 0", bus.last); end
            end
            advance();
        end
        checks++; if (delivered != 5) begin errors++; $display("[TB] FAIL stream_count: got %0d want 5", delivered); end
        checks++; if (first_rd < 0 || first_v - first_rd != 2) begin errors++; $display("[TB] FAIL stream_latency: got %0d want 2", first_v - first_rd); end
        checks++; if (last_x - first_x != 4) begin errors++; $display("[TB] FAIL stream_bubbles: got span %0d want 4", last_x - first_x); end
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, $urandom);
            advance();
        end
        for (int c = 0; c < 60 && delivered < 8; c++) begin
            drive(1'b1, (c % 2) == 0, 1'b0, '0);
            if (hold_prev) begin
                checks++; if (bus.valid !== 1'b1 || bus.data_out !== data_prev) begin errors++; $display("[TB] FAIL bp_hold: got %b/%h want 1/%h", bus.valid, bus.data_out, data_prev); end
            end
            checks++; if (occ > 2) begin errors++; $display("[TB] FAIL bp_occupancy: got %0d want <=2", occ); end
            if (bus.valid && bus.ready) begin
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL bp_data: got %h want %h", bus.data_out, exp_head()); end
                checks++; if (bus.sample_idx !== IW'(exp_idx)) begin errors++; $display("[TB] FAIL bp_idx: got %0d want %0d", bus.sample_idx, exp_idx); end
            end
            advance();
        end
        checks++; if (delivered != 8 || expq.size() != 0) begin errors++; $display("[TB] FAIL bp_count: got %0d left %0d want 8 left 0", delivered, expq.size()); end
    endtask

    task automatic test_drain();
        int rds, got;
        $display("[TB] test_drain");
        rds = 0; got = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, sample_t'(i));
            advance();
        end
        for (int c = 0; c < 10 && rds < 2; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (bus.fifo_rd) rds++;
            advance();
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL drain_no_read: got %b want 0", bus.fifo_rd); end
            if (delivered < 2) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy: got %b want 1", bus.busy); end
            end
            if (bus.valid) begin
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL drain_data: got %h want %h", bus.data_out, exp_head()); end
            end
            advance();
        end
        checks++; if (delivered != 2) begin errors++; $display("[TB] FAIL drain_count: got %0d want 2", delivered); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle: got %b want 0", bus.busy); end
        for (int c = 0; c < 10 && got == 0; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (bus.valid) begin
                got = 1;
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL resume_data: got %h want %h", bus.data_out, exp_head()); end
                checks++; if (bus.sample_idx !== IW'(exp_idx)) begin errors++; $display("[TB] FAIL resume_idx: got %0d want %0d", bus.sample_idx, exp_idx); end
            end
            advance();
        end
        checks++; if (got != 1) begin errors++; $display("[TB] FAIL resume_timeout: got %0d samples want 1", got); end
    endtask

    task automatic test_empty();
        int rd_c, v_c;
        $display("[TB] test_empty");
        rd_c = -1; v_c = -1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            checks++; if (bus.fifo_rd !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_idle: got rd=%b valid=%b want 0/0", bus.fifo_rd, bus.valid); end
            if (c > 0) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL empty_stream: got busy=%b want 1", bus.busy); end
            end
            advance();
        end
        drive(1'b1, 1'b1, 1'b1, 32'h0000_000A);
        advance();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (bus.fifo_rd && rd_c < 0) rd_c = c;
            if (bus.valid && v_c < 0) begin
                v_c = c;
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL empty_data: got %h want %h", bus.data_out, exp_head()); end
            end
            advance();
        end
        checks++; if (rd_c < 0 || v_c - rd_c != 2) begin errors++; $display("[TB] FAIL empty_latency: got rd@%0d valid@%0d want gap 2", rd_c, v_c); end
    endtask

    task automatic test_reset_mid();
        int got;
        $display("[TB] test_reset_mid");
        got = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, $urandom);
            advance();
        end
        for (int c = 0; c < 20 && delivered < 2; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            advance();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        checks++; if (bus.valid !== 1'b1 || bus.sample_idx !== IW'(exp_idx)) begin errors++; $display("[TB] FAIL rstmid_pre: got valid=%b idx=%0d want 1/%0d", bus.valid, bus.sample_idx, exp_idx); end
        rst = 1'b1;
        #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b want 0", bus.valid); end
        checks++; if (bus.sample_idx !== '0) begin errors++; $display("[TB] FAIL rstmid_idx: got %0d want 0", bus.sample_idx); end
        checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_fifo_rd: got %b want 0", bus.fifo_rd); end
        for (int k = 0; k < occ; k++) begin
            if (expq.size() != 0) void'(expq.pop_front());
        end
        occ       = 0;
        exp_idx   = 0;
        hold_prev = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (bus.valid) begin
                got = 1;
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL rstmid_data: got %h want %h", bus.data_out, exp_head()); end
                checks++; if (bus.sample_idx !== IW'(exp_idx)) begin errors++; $display("[TB] FAIL rstmid_newidx: got %0d want %0d", bus.sample_idx, exp_idx); end
            end
            advance();
        end
        checks++; if (got != 1) begin errors++; $display("[TB] FAIL rstmid_timeout: got %0d samples want 1", got); end
    endtask

    task automatic test_ready_low();
        int rds;
        $display("[TB] test_ready_low");
        rds = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, $urandom);
            advance();
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            if (bus.fifo_rd) rds++;
            advance();
        end
        checks++; if (rds != 2) begin errors++; $display("[TB] FAIL rdylow_reads: got %0d want 2", rds); end
        for (int c = 0; c < 12 && delivered < 3; c++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (bus.fifo_rd) rds++;
            if (bus.valid) begin
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL rdylow_data: got %h want %h", bus.data_out, exp_head()); end
            end
            advance();
        end
        checks++; if (delivered != 3 || rds != 3) begin errors++; $display("[TB] FAIL rdylow_count: got %0d out %0d reads want 3/3", delivered, rds); end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        do_reset();
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                drive($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                      ($urandom_range(0, 1) == 1) && (expq.size() < 40), $urandom);
            end else begin
                drive(1'b1, 1'b1, 1'b0, '0);
            end
            if (hold_prev) begin
                checks++; if (bus.valid !== 1'b1 || bus.data_out !== data_prev) begin errors++; $display("[TB] FAIL rnd_hold: got %b/%h want 1/%h", bus.valid, bus.data_out, data_prev); end
            end
            checks++; if (occ > 2) begin errors++; $display("[TB] FAIL rnd_occupancy: got %0d want <=2", occ); end
            if (bus.fifo_empty) begin
                checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL rnd_rd_empty: got %b want 0", bus.fifo_rd); end
            end
            if (bus.valid) begin
                checks++; if (bus.data_out !== exp_head()) begin errors++; $display("[TB] FAIL rnd_data: got %h want %h", bus.data_out, exp_head()); end
                checks++; if (bus.sample_idx !== IW'(exp_idx)) begin errors++; $display("[TB] FAIL rnd_idx: got %0d want %0d", bus.sample_idx, exp_idx); end
                checks++; if (bus.last !== (exp_idx == FL - 1)) begin errors++; $display("[TB] FAIL rnd_last: got %b want %b", bus.last, exp_idx == FL - 1); end
            end
            advance();
        end
        checks++; if (expq.size() != 0) begin errors++; $display("[TB] FAIL rnd_leftover: got %0d words want 0", expq.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_empty();
        test_reset_mid();
        test_ready_low();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
